// File: rtl/ps2_keyboard_host_ctrl_if.sv
// Signal bundle between the PS/2 host sequencer and its surroundings
// (byte receiver/transmitter, key memory, LED request source).
interface ps2_keyboard_host_ctrl_if;
    logic [7:0] rxByte;
    logic       rxValid;
    logic [7:0] txByte;
    logic       txStart;
    logic       txBusy;
    logic [7:0] scanCode;
    logic       scanCodeReady;
    logic       ledReq;
    logic [2:0] ledState;
    logic       initDone;
    logic       initError;

    modport master (
        input  rxByte, rxValid, txBusy, ledReq, ledState,
        output txByte, txStart, scanCode, scanCodeReady, initDone, initError
    );

    modport slave (
        output rxByte, rxValid, txBusy, ledReq, ledState,
        input  txByte, txStart, scanCode, scanCodeReady, initDone, initError
    );
endinterface

// File: rtl/ps2_keyboard_host_ctrl.sv
// PS/2 keyboard host sequencer: reset/BAT handshake, LED updates with
// resend/timeout retries, and filtering of protocol bytes from scan codes.
module ps2_keyboard_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRIES    = 3
) (
    input logic                     clk,
    input logic                     rst,
    ps2_keyboard_host_ctrl_if.master bus
);

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_LED    = 8'hED;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ECHO   = 8'hEE;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] BAT_FAIL   = 8'hFC;

    typedef enum logic [3:0] {
        RST_SEND, RST_ACK, RST_BAT, RUN,
        LED_CMD, LED_ACK1, LED_VAL, LED_ACK2, ERROR
    } state_t;

    state_t             state_q, state_n;
    logic [TMO_W-1:0]   tmo_q, tmo_n;
    logic [RETRY_W-1:0] retry_q, retry_n;
    logic               led_pending_q, led_pending_n;
    logic [2:0]         led_shadow_q, led_shadow_n;
    logic               tx_start_q, tx_start_n;
    logic [7:0]         tx_byte_q, tx_byte_n;
    logic [7:0]         scan_code_q, scan_code_n;
    logic               scan_ready_q, scan_ready_n;
    logic               init_done_q, init_done_n;
    logic               init_error_q, init_error_n;
    logic               resend;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n       = state_q;
        tmo_n         = '0;
        retry_n       = retry_q;
        led_pending_n = led_pending_q | bus.ledReq;
        led_shadow_n  = led_shadow_q;
        tx_start_n    = 1'b0;
        tx_byte_n     = tx_byte_q;
        scan_code_n   = scan_code_q;
        scan_ready_n  = 1'b0;
        resend        = 1'b0;

        unique case (state_q)
            RST_SEND, LED_CMD, LED_VAL: begin
                if (!bus.txBusy) begin
                    tx_start_n = 1'b1;
                    tx_byte_n  = (state_q == RST_SEND) ? CMD_RESET :
                                 (state_q == LED_CMD)  ? CMD_LED   : {5'b0, led_shadow_q};
                    state_n    = (state_q == RST_SEND) ? RST_ACK  :
                                 (state_q == LED_CMD)  ? LED_ACK1 : LED_ACK2;
                end
            end
            RST_ACK, LED_ACK1, LED_ACK2: begin
                if (bus.rxValid && bus.rxByte == RSP_ACK) begin
                    retry_n = '0;
                    state_n = (state_q == RST_ACK)  ? RST_BAT :
                              (state_q == LED_ACK1) ? LED_VAL : RUN;
                end else if ((bus.rxValid && bus.rxByte == RSP_RESEND) || tmo_q == TMO_LAST) begin
                    resend = 1'b1;
                end
            end
            RST_BAT: begin
                if (bus.rxValid && bus.rxByte == BAT_OK)        state_n = RUN;
                else if (bus.rxValid && bus.rxByte == BAT_FAIL) state_n = ERROR;
                else if (tmo_q == TMO_LAST)                     resend  = 1'b1;
            end
            RUN: begin
                if (bus.rxValid) begin
                    // Hot-plugged keyboard reports BAT again; its LEDs must be restored.
                    if (bus.rxByte == BAT_OK) begin
                        led_pending_n = 1'b1;
                    end else if (bus.rxByte != RSP_ACK && bus.rxByte != RSP_RESEND &&
                                 bus.rxByte != RSP_ECHO) begin
                        scan_code_n  = bus.rxByte;
                        scan_ready_n = 1'b1;
                    end
                end else if (led_pending_q) begin
                    led_shadow_n  = bus.ledState;
                    led_pending_n = 1'b0;
                    state_n       = LED_CMD;
                end
            end
            default: ;
        endcase

        if (resend) begin
            if (retry_q == RETRY_MAX) begin
                state_n = ERROR;
            end else begin
                retry_n = retry_q + 1'b1;
                state_n = (state_q == LED_ACK1) ? LED_CMD :
                          (state_q == LED_ACK2) ? LED_VAL : RST_SEND;
            end
        end

        // Counter restarts on any state change, so each wait gets a full window.
        if (state_n == state_q)
            tmo_n = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;

        init_done_n  = state_n inside {RUN, LED_CMD, LED_ACK1, LED_VAL, LED_ACK2};
        init_error_n = (state_n == ERROR);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q       <= RST_SEND;
            tmo_q         <= '0;
            retry_q       <= '0;
            led_pending_q <= 1'b1;
            led_shadow_q  <= '0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= '0;
            scan_code_q   <= '0;
            scan_ready_q  <= 1'b0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
        end else begin
            state_q       <= state_n;
            tmo_q         <= tmo_n;
            retry_q       <= retry_n;
            led_pending_q <= led_pending_n;
            led_shadow_q  <= led_shadow_n;
            tx_start_q    <= tx_start_n;
            tx_byte_q     <= tx_byte_n;
            scan_code_q   <= scan_code_n;
            scan_ready_q  <= scan_ready_n;
            init_done_q   <= init_done_n;
            init_error_q  <= init_error_n;
        end
    end

    assign bus.txStart       = tx_start_q;
    assign bus.txByte        = tx_byte_q;
    assign bus.scanCode      = scan_code_q;
    assign bus.scanCodeReady = scan_ready_q;
    assign bus.initDone      = init_done_q;
    assign bus.initError     = init_error_q;

endmodule

// File: tb/tb_ps2_keyboard_host_ctrl.sv
// Self-checking bench for the PS/2 host sequencer: init handshake, forwarding,
// LED updates, resend/timeout retries, error, mid-operation reset.
module tb_ps2_keyboard_host_ctrl;

    localparam int TMO     = 100;
    localparam int RETRIES = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_keyboard_host_ctrl_if bus ();

    ps2_keyboard_host_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    logic [7:0]  tx_log[$];
    int unsigned tx_time[$];
    logic [7:0]  scan_log[$];

    typedef struct {
        logic [7:0] rx;
        bit         fwd;
    } vec_t;
    vec_t vecs[9];

    always @(posedge clk) cycle <= cycle + 1;

    // Passive observer of transmit starts and forwarded scan codes.
    always @(negedge clk) begin
        if (bus.txStart) begin
            tx_log.push_back(bus.txByte);
            tx_time.push_back(cycle);
        end
        if (bus.scanCodeReady) scan_log.push_back(bus.scanCode);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rxByte  = b;
        bus.rxValid = 1'b1;
        step();
        bus.rxValid = 1'b0;
    endtask

    task automatic wait_tx(input string name, input logic [7:0] exp, output int unsigned t);
        int n;
        logic [7:0] b;
        n = 0;
        t = 0;
        while (tx_log.size() == 0 && n < 400) begin
            step();
            n++;
        end
        if (tx_log.size() == 0) begin
            check({name, "_present"}, 32'(tx_log.size()), 1);
        end else begin
            b = tx_log.pop_front();
            t = tx_time.pop_front();
            check(name, b, exp);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_txStart"}, bus.txStart, 0);
        check({pfx, "_txByte"}, bus.txByte, 0);
        check({pfx, "_scanReady"}, bus.scanCodeReady, 0);
        check({pfx, "_scanCode"}, bus.scanCode, 0);
        check({pfx, "_initDone"}, bus.initDone, 0);
        check({pfx, "_initError"}, bus.initError, 0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.rxValid  = 1'b0;
        bus.rxByte   = '0;
        bus.txBusy   = 1'b0;
        bus.ledReq   = 1'b0;
        bus.ledState = '0;
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        tx_log.delete();
        tx_time.delete();
        scan_log.delete();
    endtask

    task automatic init_keyboard();
        int unsigned t;
        do_reset();
        wait_tx("init_ff", 8'hFF, t);
        send_rx(8'hFA);
        check("init_done_before_bat", bus.initDone, 0);
        send_rx(8'hAA);
        check("init_done_after_bat", bus.initDone, 1);
        wait_tx("init_led_cmd", 8'hED, t);
        send_rx(8'hFA);
        wait_tx("init_led_val", 8'h00, t);
        send_rx(8'hFA);
        step();
        check("init_done_run", bus.initDone, 1);
    endtask

    initial begin
        int unsigned t;
        int unsigned times[4];
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        int          nmin;

        vecs[0] = '{8'h1C, 1'b1};
        vecs[1] = '{8'hF0, 1'b1};
        vecs[2] = '{8'h1C, 1'b1};
        vecs[3] = '{8'hFA, 1'b0};
        vecs[4] = '{8'hEE, 1'b0};
        vecs[5] = '{8'hFE, 1'b0};
        vecs[6] = '{8'hE0, 1'b1};
        vecs[7] = '{8'h00, 1'b1};
        vecs[8] = '{8'hFC, 1'b1};

        // Normal init, including the initial LED sequence.
        init_keyboard();

        // Table-driven forwarding in RUN.
        foreach (vecs[i]) begin
            send_rx(vecs[i].rx);
            check($sformatf("fwd_ready_%0d", i), bus.scanCodeReady, vecs[i].fwd);
            if (vecs[i].fwd) check($sformatf("fwd_code_%0d", i), bus.scanCode, vecs[i].rx);
            step();
            check($sformatf("fwd_pulse_end_%0d", i), bus.scanCodeReady, 0);
        end
        check("fwd_no_tx", 32'(tx_log.size()), 0);

        // LED update on request.
        bus.ledState = 3'b100;
        bus.ledReq   = 1'b1;
        step();
        bus.ledReq = 1'b0;
        wait_tx("led_cmd", 8'hED, t);
        check("led_init_done_held", bus.initDone, 1);
        send_rx(8'hFA);
        wait_tx("led_val", 8'h04, t);
        send_rx(8'hFA);
        step();
        send_rx(8'h2B);
        check("led_back_to_run", bus.scanCode, 8'h2B);

        // Hot-plug BAT in RUN: not forwarded, LEDs restored.
        bus.ledState = 3'b010;
        send_rx(8'hAA);
        check("hotplug_no_fwd", bus.scanCodeReady, 0);
        wait_tx("hotplug_cmd", 8'hED, t);
        send_rx(8'hFA);
        wait_tx("hotplug_val", 8'h02, t);
        send_rx(8'hFA);
        step();

        // Simultaneous ledReq and scan byte: byte wins, LED follows.
        bus.ledState = 3'b011;
        bus.ledReq   = 1'b1;
        send_rx(8'h1D);
        bus.ledReq = 1'b0;
        check("simul_fwd_ready", bus.scanCodeReady, 1);
        check("simul_fwd_code", bus.scanCode, 8'h1D);
        check("simul_tx_later", 32'(tx_log.size()), 0);
        wait_tx("simul_cmd", 8'hED, t);
        send_rx(8'hFA);
        wait_tx("simul_val", 8'h03, t);
        send_rx(8'hFA);
        repeat (2) step();

        // Randomized RUN traffic against a forwarding-rule model.
        scan_log.delete();
        tx_log.delete();
        tx_time.delete();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: b = 8'hFA;
                    1: b = 8'hFE;
                    default: b = 8'hEE;
                endcase
            end else begin
                b = 8'($urandom);
                if (b == 8'hAA) b = 8'h1C;
            end
            bus.rxByte  = b;
            bus.rxValid = 1'($urandom_range(0, 1));
            if (bus.rxValid && !(b inside {8'hFA, 8'hFE, 8'hEE, 8'hAA})) exp_q.push_back(b);
            step();
        end
        bus.rxValid = 1'b0;
        repeat (3) step();
        check("rand_count", 32'(scan_log.size()), 32'(exp_q.size()));
        nmin = (scan_log.size() < exp_q.size()) ? scan_log.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check($sformatf("rand_code_%0d", i), scan_log[i], exp_q[i]);
        check("rand_no_tx", 32'(tx_log.size()), 0);

        // Reset in the middle of an LED sequence while transmitter is busy.
        bus.ledState = 3'b001;
        bus.ledReq   = 1'b1;
        step();
        bus.ledReq = 1'b0;
        wait_tx("midrst_cmd", 8'hED, t);
        bus.txBusy = 1'b1;
        rst        = 1'b1;
        step();
        check_outputs_zero("midrst");
        rst = 1'b0;
        tx_log.delete();
        tx_time.delete();
        repeat (10) step();
        check("midrst_busy_hold", 32'(tx_log.size()), 0);
        bus.txBusy = 1'b0;
        wait_tx("midrst_ff", 8'hFF, t);
        check("midrst_not_done", bus.initDone, 0);

        // Resend twice during init.
        do_reset();
        wait_tx("resend_ff0", 8'hFF, t);
        send_rx(8'hFE);
        wait_tx("resend_ff1", 8'hFF, t);
        send_rx(8'hFE);
        wait_tx("resend_ff2", 8'hFF, t);
        send_rx(8'hFA);
        send_rx(8'hAA);
        check("resend_done", bus.initDone, 1);
        wait_tx("resend_next_is_led", 8'hED, t);

        // Silent keyboard: timeouts exhaust retries and latch error.
        do_reset();
        for (int i = 0; i < 4; i++) wait_tx($sformatf("tmo_ff_%0d", i), 8'hFF, times[i]);
        for (int i = 1; i < 4; i++)
            check($sformatf("tmo_gap_%0d", i),
                  32'((times[i] - times[i-1]) >= 95 && (times[i] - times[i-1]) <= 110), 1);
        repeat (300) step();
        check("tmo_no_more_tx", 32'(tx_log.size()), 0);
        check("tmo_error", bus.initError, 1);
        check("tmo_not_done", bus.initDone, 0);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h1C);
        check("error_sticky", bus.initError, 1);
        check("error_no_fwd", bus.scanCodeReady, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
